// File: rtl/arbiter_puf_engine.sv
// rtl/arbiter_puf_engine.sv - sequential arbiter-PUF evaluation engine with jitter and majority voting
//
// Runs M delay-race chains of N stages, one stage per clock, then arbitrates
// each chain. The whole race is repeated VOTES times and majority-voted.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request pulse, accepted only while idle
//   challenge  N-bit challenge, latched when start is accepted
//   busy       high whenever an evaluation is in progress
//   done       one-cycle pulse; response/unstable are valid from this cycle
//   response   M-bit majority-voted response, held until the next done
//   unstable   per-chain flag, set when the votes were not unanimous
module arbiter_puf_engine #(
    parameter int                      N       = 4,
    parameter int                      M       = 1,
    parameter int                      DW      = 4,
    parameter logic [2*N*M*DW-1:0]     DELAY   = 32'h12121212,
    parameter int                      VOTES   = 1,
    parameter int                      NOISE_W = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] challenge,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] response,
    output logic [M-1:0] unstable
);

    // Accumulators hold at most N delays plus N jitter values of DW bits each.
    localparam int AW = DW + 1 + $clog2(N);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int VW = $clog2(VOTES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RACE = 2'd1;
    localparam logic [1:0] S_ARB  = 2'd2;

    localparam logic [15:0]   JMASK     = 16'((32'd1 << NOISE_W) - 32'd1);
    localparam logic [SW-1:0] LAST_STG  = SW'(N - 1);
    localparam logic [VW-1:0] LAST_VOTE = VW'(VOTES - 1);
    localparam logic [VW-1:0] HALF      = VW'(VOTES / 2);
    localparam logic [VW-1:0] ALL_VOTES = VW'(VOTES);
    localparam logic [VW-1:0] ONE       = VW'(1);

    logic [1:0]    state;
    logic [SW-1:0] stage;
    logic [VW-1:0] votes_done;
    logic [N-1:0]  chal_q;
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [AW-1:0] jit;

    logic [AW-1:0] top_q  [M];
    logic [AW-1:0] bot_q  [M];
    logic [AW-1:0] top_nx [M];
    logic [AW-1:0] bot_nx [M];
    logic [AW-1:0] d_top  [M];
    logic [AW-1:0] d_bot  [M];
    logic [VW-1:0] ones_q [M];
    logic [VW-1:0] ones_nx[M];
    logic [M-1:0]  win;
    logic [M-1:0]  resp_nx;
    logic [M-1:0]  unst_nx;

    assign busy    = (state != S_IDLE);
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // Jitter is the low NOISE_W bits of the LFSR; the mask is zero when jitter is off.
    assign jit     = AW'(lfsr & JMASK);

    always_comb begin
        for (int m = 0; m < M; m++) begin
            d_top[m] = {{(AW-DW){1'b0}}, DELAY[DW*(2*(m*N+int'(stage)))   +: DW]};
            d_bot[m] = {{(AW-DW){1'b0}}, DELAY[DW*(2*(m*N+int'(stage))+1) +: DW]};
            // A crossed stage swaps which running total feeds each output path.
            if (chal_q[stage]) begin
                top_nx[m] = bot_q[m] + d_top[m] + jit;
                bot_nx[m] = top_q[m] + d_bot[m];
            end else begin
                top_nx[m] = top_q[m] + d_top[m] + jit;
                bot_nx[m] = bot_q[m] + d_bot[m];
            end
            // Ties resolve to 0: the top edge must arrive strictly first.
            win[m]     = (top_q[m] < bot_q[m]);
            ones_nx[m] = win[m] ? (ones_q[m] + ONE) : ones_q[m];
            resp_nx[m] = (ones_nx[m] > HALF);
            unst_nx[m] = (ones_nx[m] != '0) && (ones_nx[m] != ALL_VOTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            stage      <= '0;
            votes_done <= '0;
            chal_q     <= '0;
            lfsr       <= 16'hACE1;
            done       <= 1'b0;
            response   <= '0;
            unstable   <= '0;
            for (int m = 0; m < M; m++) begin
                top_q[m]  <= '0;
                bot_q[m]  <= '0;
                ones_q[m] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chal_q     <= challenge;
                        stage      <= '0;
                        votes_done <= '0;
                        for (int m = 0; m < M; m++) begin
                            top_q[m]  <= '0;
                            bot_q[m]  <= '0;
                            ones_q[m] <= '0;
                        end
                        state <= S_RACE;
                    end
                end
                S_RACE: begin
                    for (int m = 0; m < M; m++) begin
                        top_q[m] <= top_nx[m];
                        bot_q[m] <= bot_nx[m];
                    end
                    lfsr <= {lfsr[14:0], lfsr_fb};
                    if (stage == LAST_STG) begin
                        stage <= '0;
                        state <= S_ARB;
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                S_ARB: begin
                    for (int m = 0; m < M; m++) begin
                        ones_q[m] <= ones_nx[m];
                        top_q[m]  <= '0;
                        bot_q[m]  <= '0;
                    end
                    if (votes_done == LAST_VOTE) begin
                        response <= resp_nx;
                        unstable <= unst_nx;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        votes_done <= votes_done + ONE;
                        state      <= S_RACE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// tb/tb_arbiter_puf_engine.sv - self-checking bench for arbiter_puf_engine
module tb_arbiter_puf_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] DELAY_A = 32'h12121212;
    localparam logic [63:0] DELAY_B = 64'h21212121_12121212;
    localparam logic [31:0] DELAY_D = 32'h91919191;

    int m_of    [4] = '{1, 2, 1, 1};
    int votes_of[4] = '{1, 1, 3, 5};
    int noise_of[4] = '{0, 0, 0, 4};

    logic [3:0] start = '0;
    logic [3:0] chal [4];
    logic [3:0] busy;
    logic [3:0] done;
    logic       resp_a, unst_a, resp_c, unst_c, resp_d, unst_d;
    logic [1:0] resp_b, unst_b;

    arbiter_puf_engine #(.N(4), .M(1), .DW(4), .DELAY(DELAY_A), .VOTES(1), .NOISE_W(0)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .challenge(chal[0]),
        .busy(busy[0]), .done(done[0]), .response(resp_a), .unstable(unst_a));
    arbiter_puf_engine #(.N(4), .M(2), .DW(4), .DELAY(DELAY_B), .VOTES(1), .NOISE_W(0)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .challenge(chal[1]),
        .busy(busy[1]), .done(done[1]), .response(resp_b), .unstable(unst_b));
    arbiter_puf_engine #(.N(4), .M(1), .DW(4), .DELAY(DELAY_A), .VOTES(3), .NOISE_W(0)) dut_c (
        .clk(clk), .rst(rst), .start(start[2]), .challenge(chal[2]),
        .busy(busy[2]), .done(done[2]), .response(resp_c), .unstable(unst_c));
    arbiter_puf_engine #(.N(4), .M(1), .DW(4), .DELAY(DELAY_D), .VOTES(5), .NOISE_W(4)) dut_d (
        .clk(clk), .rst(rst), .start(start[3]), .challenge(chal[3]),
        .busy(busy[3]), .done(done[3]), .response(resp_d), .unstable(unst_d));

    function automatic logic [15:0] get_resp(input int i);
        case (i)
            0:       return 16'(resp_a);
            1:       return 16'(resp_b);
            2:       return 16'(resp_c);
            default: return 16'(resp_d);
        endcase
    endfunction

    function automatic logic [15:0] get_unst(input int i);
        case (i)
            0:       return 16'(unst_a);
            1:       return 16'(unst_b);
            2:       return 16'(unst_c);
            default: return 16'(unst_d);
        endcase
    endfunction

    function automatic logic [255:0] get_delay(input int i);
        case (i)
            1:       return 256'(DELAY_B);
            3:       return 256'(DELAY_D);
            default: return 256'(DELAY_A);
        endcase
    endfunction

    // Reference race model, starting from a freshly seeded LFSR; returns {unstable, response}.
    function automatic logic [31:0] model(input int i, input logic [3:0] c);
        logic [255:0] d, sh;
        logic [15:0]  lf, r, u;
        int top[16], bot[16], ones[16];
        int jit, dt, db, t;
        d  = get_delay(i);
        lf = 16'hACE1;
        r  = '0;
        u  = '0;
        for (int ch = 0; ch < 16; ch++) ones[ch] = 0;
        for (int v = 0; v < votes_of[i]; v++) begin
            for (int ch = 0; ch < 16; ch++) begin
                top[ch] = 0;
                bot[ch] = 0;
            end
            for (int j = 0; j < 4; j++) begin
                jit = (noise_of[i] == 0) ? 0 : (int'(lf) % (1 << noise_of[i]));
                for (int ch = 0; ch < m_of[i]; ch++) begin
                    sh = d >> (4 * (2 * (ch * 4 + j)));
                    dt = int'(sh[3:0]);
                    sh = d >> (4 * (2 * (ch * 4 + j) + 1));
                    db = int'(sh[3:0]);
                    if (c[j]) begin
                        t       = top[ch];
                        top[ch] = bot[ch] + dt + jit;
                        bot[ch] = t + db;
                    end else begin
                        top[ch] = top[ch] + dt + jit;
                        bot[ch] = bot[ch] + db;
                    end
                end
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            end
            for (int ch = 0; ch < m_of[i]; ch++)
                if (top[ch] < bot[ch]) ones[ch]++;
        end
        for (int ch = 0; ch < m_of[i]; ch++) begin
            r[ch] = (ones[ch] * 2 > votes_of[i]);
            u[ch] = (ones[ch] != 0) && (ones[ch] != votes_of[i]);
        end
        return {u, r};
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst %0d cyc %0d got %0h exp %0h", name, inst, cyc, got, exp);
        end
    endtask

    typedef struct {
        int          inst;
        logic [15:0] resp;
        logic [15:0] unst;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] hold_r[4];
    logic [15:0] hold_u[4];

    // Scoreboard side: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (done[i]) begin
                    if (sb.size() == 0 || sb[0].inst != i) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done inst %0d cyc %0d got 1 exp 0", i, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("response", i, 32'(get_resp(i)), 32'(mon_e.resp));
                        chk("unstable", i, 32'(get_unst(i)), 32'(mon_e.unst));
                        chk("latency", i, cyc, mon_e.due);
                        chk("busy_in_done", i, 32'(busy[i]), 32'd0);
                        hold_r[i] = mon_e.resp;
                        hold_u[i] = mon_e.unst;
                    end
                end else begin
                    chk("hold_response", i, 32'(get_resp(i)), 32'(hold_r[i]));
                    chk("hold_unstable", i, 32'(get_unst(i)), 32'(hold_u[i]));
                end
            end
        end
    end

    task automatic start_req(input int i, input logic [3:0] c, input logic [15:0] r, input logic [15:0] u);
        exp_t e;
        @(posedge clk);
        #1;
        start[i] = 1'b1;
        chal[i]  = c;
        e.inst = i;
        e.resp = r;
        e.unst = u;
        e.due  = cyc + votes_of[i] * 5 + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", -1, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            hold_r[i] = '0;
            hold_u[i] = '0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int          inst;
        logic [3:0]  chal;
        logic [15:0] resp;
        logic [15:0] unst;
    } vec_t;

    vec_t        vt[10];
    logic [31:0] mr;
    logic [3:0]  rc;
    int          c0;

    initial begin
        vt[0] = '{0, 4'b0000, 16'h0, 16'h0};
        vt[1] = '{0, 4'b1000, 16'h1, 16'h0};
        vt[2] = '{0, 4'b1010, 16'h0, 16'h0};
        vt[3] = '{0, 4'b1111, 16'h0, 16'h0};
        vt[4] = '{0, 4'b1001, 16'h1, 16'h0};
        vt[5] = '{0, 4'b1100, 16'h0, 16'h0};
        vt[6] = '{1, 4'b0000, 16'h2, 16'h0};
        vt[7] = '{1, 4'b1000, 16'h1, 16'h0};
        vt[8] = '{2, 4'b1000, 16'h1, 16'h0};
        vt[9] = '{2, 4'b0000, 16'h0, 16'h0};

        for (int i = 0; i < 4; i++) begin
            chal[i]   = '0;
            hold_r[i] = '0;
            hold_u[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_busy", i, 32'(busy[i]), 32'd0);
            chk("reset_done", i, 32'(done[i]), 32'd0);
            chk("reset_response", i, 32'(get_resp(i)), 32'd0);
            chk("reset_unstable", i, 32'(get_unst(i)), 32'd0);
        end
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            start_req(vt[k].inst, vt[k].chal, vt[k].resp, vt[k].unst);
            drain();
        end

        for (int i = 1; i <= 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                rc = 4'($urandom_range(0, 15));
                mr = model(i, rc);
                start_req(i, rc, mr[15:0], mr[31:16]);
                drain();
            end
        end

        // Back-to-back: second start lands in the done cycle of the first.
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        chal[0]  = 4'b1000;
        c0       = cyc;
        sb.push_back('{0, 16'h1, 16'h0, c0 + 6});
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_done_cycle", 0, 32'(done[0]), 32'd1);
        start[0] = 1'b1;
        chal[0]  = 4'b0000;
        sb.push_back('{0, 16'h0, 16'h0, cyc + 6});
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        drain();

        // Start pulses and challenge changes while busy are ignored.
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        chal[0]  = 4'b1000;
        sb.push_back('{0, 16'h1, 16'h0, cyc + 6});
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            start[0] = (k == 2 || k == 4);
            chal[0]  = 4'b0000;
            if (k == 2) chk("busy_mid_run", 0, 32'(busy[0]), 32'd1);
        end
        drain();
        repeat (12) @(posedge clk);

        // Reset in the third RACE cycle aborts the evaluation and clears the result.
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        chal[0]  = 4'b1000;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            hold_r[i] = '0;
            hold_u[i] = '0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_response", 0, 32'(get_resp(0)), 32'd0);
        chk("abort_unstable", 0, 32'(get_unst(0)), 32'd0);
        chk("abort_busy", 0, 32'(busy[0]), 32'd0);

        // Jittered, voted runs are reproducible after reset.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            mr = model(3, 4'b0110);
            start_req(3, 4'b0110, mr[15:0], mr[31:16]);
            drain();
            mr = model(3, 4'b1111);
            do_reset();
            start_req(3, 4'b1111, mr[15:0], mr[31:16]);
            drain();
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
